// File: rtl/if_prefetch_queue_pkg.sv
// Shared types and helpers for the instruction prefetch queue.
// Holds the queue entry layout, the PC step and the ROM word-address mapping.
package if_prefetch_queue_pkg;

    localparam logic [31:0] DEFAULT_NOP_IR = 32'hFFFF_FFFF;
    localparam logic [31:0] PC_STEP        = 32'd4;

    typedef struct packed {
        logic [31:0] npc;
        logic [31:0] ir;
    } entry_t;

    // Byte PC to ROM word index; the low two bits select a byte and are dropped.
    function automatic logic [29:0] pc_word(input logic [31:0] pc);
        return pc[31:2];
    endfunction

endpackage

// File: rtl/if_prefetch_queue_if.sv
// Instruction-ROM read port plus the {IR, NPC} valid/ready output channel.
// The master side is the prefetch queue; the slave side is ROM plus consumer.
interface if_prefetch_queue_if #(
    parameter int ADDR_W = 8
);
    logic              imem_rd;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_ir;
    logic [31:0]       out_npc;

    modport master (
        output imem_rd, imem_addr, out_valid, out_ir, out_npc,
        input  imem_data, out_ready
    );

    modport slave (
        input  imem_rd, imem_addr, out_valid, out_ir, out_npc,
        output imem_data, out_ready
    );
endinterface

// File: rtl/if_prefetch_queue_fifo.sv
// DEPTH-entry circular buffer of {npc, ir} with head/tail/count and a flush.
// Callers guarantee no push when full and no pop when empty.
module prefetch_fifo
    import if_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;

    // NOTE: storage has no reset; count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[head];

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch ahead of IF/ID: issues sequential ROM reads under a credit
// limit, queues {IR, NPC} pairs, and flushes everything on an EX branch redirect.
module if_prefetch_queue
    import if_prefetch_queue_pkg::*;
#(
    parameter int          DEPTH  = 4,
    parameter int          ADDR_W = 8,
    parameter logic [31:0] NOP_IR = DEFAULT_NOP_IR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    output logic [31:0]            fetch_pc,
    output logic [$clog2(DEPTH):0] occupancy,
    if_prefetch_queue_if.master    bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic           inflight;
    logic [31:0]    tag;
    logic           issue;
    logic           push;
    logic           pop;
    logic [CNT_W:0] credits_used;
    entry_t         head;
    entry_t         resp;

    // A read is only issued when its response is guaranteed a free slot.
    assign credits_used = {1'b0, occupancy} + {{CNT_W{1'b0}}, inflight};
    assign issue        = !rst && !redirect && (credits_used < (CNT_W+1)'(DEPTH));

    // Redirect outranks both the pending response and a consumer pop.
    assign push = inflight && !redirect;
    assign pop  = bus.out_valid && bus.out_ready && !redirect;

    assign resp.ir  = bus.imem_data;
    assign resp.npc = tag + PC_STEP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= '0;
            inflight <= 1'b0;
            tag      <= '0;
        end else begin
            inflight <= issue;
            if (redirect) begin
                fetch_pc <= redirect_pc;
            end else if (issue) begin
                fetch_pc <= fetch_pc + PC_STEP;
                tag      <= fetch_pc;
            end
        end
    end

    prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect),
        .push      (push),
        .push_data (resp),
        .pop       (pop),
        .head_data (head),
        .count     (occupancy)
    );

    assign bus.imem_rd   = issue;
    assign bus.imem_addr = ADDR_W'(pc_word(fetch_pc));
    assign bus.out_valid = (occupancy != '0);
    assign bus.out_ir    = bus.out_valid ? head.ir  : NOP_IR;
    assign bus.out_npc   = bus.out_valid ? head.npc : '0;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed plus randomized bench for if_prefetch_queue against a queue-based
// model of fetch PC, one outstanding read and the {IR, NPC} FIFO.
module tb_if_prefetch_queue;
    import if_prefetch_queue_pkg::*;

    localparam int          DEPTH  = 4;
    localparam int          ADDR_W = 8;
    localparam logic [31:0] NOP    = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] fetch_pc;
    logic [2:0]  occupancy;

    int checks = 0;
    int errors = 0;

    entry_t      mq[$];
    bit          m_inflight;
    logic [31:0] m_tag;
    logic [31:0] m_pc;

    if_prefetch_queue_if #(.ADDR_W(ADDR_W)) bus ();

    if_prefetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_IR(NOP)) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_pc    (fetch_pc),
        .occupancy   (occupancy),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [ADDR_W-1:0] a);
        return 32'h1000_0000 + 32'(a);
    endfunction

    // Synchronous ROM: data for the address read at an edge appears after it.
    always @(posedge clk) begin
        if (bus.imem_rd) bus.imem_data <= rom_word(bus.imem_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_inflight = 1'b0;
        m_tag      = '0;
        m_pc       = '0;
    endtask

    task automatic check_reset_values();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_ir",    bus.out_ir,         NOP);
        check("rst_out_npc",   bus.out_npc,        32'd0);
        check("rst_occupancy", 32'(occupancy),     32'd0);
        check("rst_imem_rd",   32'(bus.imem_rd),   32'd0);
        check("rst_fetch_pc",  fetch_pc,           32'd0);
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance it.
    task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy);
        bit     exp_rd;
        entry_t e;
        @(negedge clk);
        redirect      = redir;
        redirect_pc   = rpc;
        bus.out_ready = rdy;
        #1;
        exp_rd = !redir && ((mq.size() + int'(m_inflight)) < DEPTH);
        check("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
        check("out_ir",    bus.out_ir,  (mq.size() != 0) ? mq[0].ir  : NOP);
        check("out_npc",   bus.out_npc, (mq.size() != 0) ? mq[0].npc : 32'd0);
        check("occupancy", 32'(occupancy), 32'(mq.size()));
        check("imem_rd",   32'(bus.imem_rd), 32'(exp_rd));
        check("imem_addr", 32'(bus.imem_addr), 32'(m_pc[ADDR_W+1:2]));
        check("fetch_pc",  fetch_pc, m_pc);
        @(posedge clk);
        if (redir) begin
            mq.delete();
            m_inflight = 1'b0;
            m_pc       = rpc;
        end else begin
            if (mq.size() != 0 && rdy) void'(mq.pop_front());
            if (m_inflight) begin
                e.ir  = rom_word(m_tag[ADDR_W+1:2]);
                e.npc = m_tag + 32'd4;
                mq.push_back(e);
            end
            m_inflight = exp_rd;
            if (exp_rd) begin
                m_tag = m_pc;
                m_pc  = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        bus.imem_data = '0;
        bus.out_ready = 1'b0;
        model_reset();

        // Reset state, then release just after an edge.
        #2;
        check_reset_values();
        @(posedge clk);
        #1 rst = 1'b0;

        // Streaming: word 0 is visible two cycles after its issue.
        step(0, 0, 1);
        step(0, 0, 1);
        #1;
        check("first_ir",  bus.out_ir,  32'h1000_0000);
        check("first_npc", bus.out_npc, 32'd4);
        for (int i = 0; i < 6; i++) step(0, 0, 1);

        // Consumer stall: queue saturates and reads stop.
        for (int i = 0; i < 10; i++) step(0, 0, 0);
        #1;
        check("stall_occ",     32'(occupancy),   32'd4);
        check("stall_imem_rd", 32'(bus.imem_rd), 32'd0);

        // Three entries plus one read in flight, then redirect to 0x40.
        step(0, 0, 1);
        step(0, 0, 0);
        #1;
        check("pre_redir_occ", 32'(occupancy), 32'd3);
        step(1, 32'h40, 1);
        #1;
        check("redir_occ",  32'(occupancy),     32'd0);
        check("redir_ir",   bus.out_ir,         NOP);
        check("redir_addr", 32'(bus.imem_addr), 32'd16);
        step(0, 0, 0);
        step(0, 0, 0);
        #1;
        check("redir_tgt_ir",  bus.out_ir,  32'h1000_0010);
        check("redir_tgt_npc", bus.out_npc, 32'h44);
        for (int i = 0; i < 4; i++) step(0, 0, 1);

        // Back-to-back redirects: the second one wins.
        step(1, 32'h40, 1);
        step(1, 32'h80, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        #1;
        check("b2b_ir",  bus.out_ir,  32'h1000_0020);
        check("b2b_npc", bus.out_npc, 32'h84);
        for (int i = 0; i < 4; i++) step(0, 0, 1);

        // PC wrap at the top of the address space.
        step(1, 32'hFFFF_FFF8, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        #1;
        check("wrap_pc", fetch_pc, 32'd0);
        step(0, 0, 0);
        step(0, 0, 1);
        #1;
        check("wrap_npc", bus.out_npc, 32'd0);
        check("wrap_ir",  bus.out_ir,  32'h1000_00FF);

        // Randomized ready/redirect traffic, including misaligned targets.
        for (int i = 0; i < 400; i++) begin
            automatic bit          r   = ($urandom_range(0, 99) < 6);
            automatic logic [31:0] pc  = $urandom();
            automatic bit          rdy = ($urandom_range(0, 99) < 70);
            step(r, pc, rdy);
        end

        // Asynchronous reset with entries held and a read in flight.
        step(1, 32'h100, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_values();
        model_reset();
        redirect      = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        step(0, 0, 1);
        step(0, 0, 1);
        #1;
        check("restart_ir",  bus.out_ir,  32'h1000_0000);
        check("restart_npc", bus.out_npc, 32'd4);
        for (int i = 0; i < 6; i++) step(0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
